// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RV32I load/store initiator for a word-addressed data memory
// Handles sub-word extension on loads and read-modify-write for SB/SH.
module lsu_mem_master #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        Memwrite,
  output logic        Memread,
  input  logic [31:0] read_data
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [AW-1:0] r_idx;
  logic [1:0]  r_ofs;
  logic [31:0] r_wdata;
  logic [31:0] r_old;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_misal;
  logic        w_oor;
  logic        w_illegal;
  logic        w_err;
  logic [4:0]  w_sh;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_wr_word;
  logic        w_bus_live;

  always_comb begin
    w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_oor     = (req_addr[31:2] >= LP_WORDS);
    w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
    w_err     = w_misal || w_oor || w_illegal;
  end

  // Halves are always 2-byte aligned here, so one shift serves bytes and halves.
  assign w_sh      = {r_ofs, 3'b000};
  assign w_shifted = read_data >> w_sh;

  always_comb begin
    w_load_data = read_data;
    case (r_f3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = read_data;
    endcase
  end

  always_comb begin
    w_wr_word = r_wdata;
    case (r_f3[1:0])
      2'b00:   w_wr_word = (r_old & ~(32'h0000_00FF << w_sh)) |
                           ({24'h0, r_wdata[7:0]} << w_sh);
      2'b01:   w_wr_word = (r_old & ~(32'h0000_FFFF << w_sh)) |
                           ({16'h0, r_wdata[15:0]} << w_sh);
      default: w_wr_word = r_wdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err)
            w_next = S_RESP;
          else if (req_store && (req_funct3 == 3'b010))
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
      S_READ:  w_next = r_store ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_f3    <= 3'b000;
      r_idx   <= '0;
      r_ofs   <= 2'b00;
      r_wdata <= 32'h0;
      r_old   <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            r_f3    <= req_funct3;
            r_idx   <= req_addr[AW+1:2];
            r_ofs   <= req_addr[1:0];
            r_wdata <= req_wdata;
            r_rdata <= 32'h0;
            r_err   <= w_err;
          end
        end
        S_READ: begin
          r_old <= read_data;
          if (!r_store) r_rdata <= w_load_data;
        end
        default: ;
      endcase
    end
  end

  // Errored requests never drive the bus, so an out-of-range index stays off it.
  assign w_bus_live = (r_state != S_IDLE) && !r_err;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;
  assign resp_error = resp_valid ? r_err : 1'b0;
  assign Memread    = (r_state == S_READ);
  assign Memwrite   = (r_state == S_WRITE);
  assign address    = w_bus_live ? 32'(r_idx) : 32'h0;
  assign write_data = w_bus_live ? w_wr_word : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] address, write_data;
  logic        Memwrite, Memread;
  logic [31:0] read_data;

  logic [31:0] mem [32];

  lsu_mem_master #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .address(address), .write_data(write_data),
    .Memwrite(Memwrite), .Memread(Memread), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = (address < 32) ? mem[address[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (Memwrite && (address < 32)) mem[address[4:0]] <= write_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, tot_wr = 0;
  int first_lat = 0;
  bit seen = 0;
  logic [31:0] cap_rd;
  logic        cap_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && req_valid && req_ready) begin
      acc_cyc = cyc + 1;
      rd_cnt = 0;
      wr_cnt = 0;
    end
    if (Memread) rd_cnt++;
    if (Memwrite) begin
      wr_cnt++;
      tot_wr++;
    end
    if (Memread || Memwrite) chk("bus_exclusive", {31'h0, Memread & Memwrite}, 32'h0);
    if (resp_valid) begin
      if (!seen) begin
        seen = 1;
        first_lat = cyc - acc_cyc + 1;
        cap_rd = resp_rdata;
        cap_e = resp_error;
      end else begin
        chk("stable_rdata", resp_rdata, cap_rd);
        chk("stable_err", {31'h0, resp_error}, {31'h0, cap_e});
      end
      if (!resp_ready) chk("busy_req_ready", {31'h0, req_ready}, 32'h0);
      if (resp_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_resp: got response with empty queue, expected none");
        end else begin
          e = q.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("error", {31'h0, resp_error}, {31'h0, e.err});
          chk("latency", first_lat, e.lat);
          chk("memread_cycles", rd_cnt, e.nrd);
          chk("memwrite_cycles", wr_cnt, e.nwr);
        end
        seen = 0;
        n_done++;
      end
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input int nrd, input int nwr, input int stall);
    exp_t e;
    int d0;
    int t;
    @(posedge clk); #1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    e.rdata = er; e.err = ee; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
    q.push_back(e);
    d0 = n_done;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (stall > 0) resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    t = 0;
    while (n_done == d0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (n_done == d0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no response for addr %h, expected one within 50 cycles", a);
    end
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic [31:0] snap;
  int          wr_snap;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1] = 32'h8081_7F02;
    mem[2] = 32'h1122_3344;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_strobes", {30'h0, Memread, Memwrite}, 32'h0);

    do_req(0, F_B,  32'h5, 0, 32'h0000_007F, 0, 2, 1, 0, 0);
    do_req(0, F_B,  32'h6, 0, 32'hFFFF_FF81, 0, 2, 1, 0, 0);
    do_req(0, F_BU, 32'h7, 0, 32'h0000_0080, 0, 2, 1, 0, 0);
    do_req(0, F_H,  32'h6, 0, 32'hFFFF_8081, 0, 2, 1, 0, 0);
    do_req(0, F_HU, 32'h4, 0, 32'h0000_7F02, 0, 2, 1, 0, 0);
    do_req(0, F_W,  32'h4, 0, 32'h8081_7F02, 0, 2, 1, 0, 0);

    do_req(1, F_B, 32'h9, 32'h0000_00AB, 32'h0, 0, 3, 1, 1, 0);
    chk("sb_mem2", mem[2], 32'h1122_AB44);
    mem[2] = 32'h1122_3344;
    do_req(1, F_H, 32'hA, 32'h0000_BEEF, 32'h0, 0, 3, 1, 1, 0);
    chk("sh_mem2", mem[2], 32'hBEEF_3344);

    do_req(1, F_W, 32'h7C, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1, 0);
    chk("sw_mem31", mem[31], 32'hDEAD_BEEF);
    do_req(1, F_W, 32'h80, 32'h1234_5678, 32'h0, 1, 1, 0, 0, 0);
    chk("sw_oor_mem0", mem[0], 32'h0);

    do_req(0, F_W,    32'h6, 0, 32'h0, 1, 1, 0, 0, 5);
    do_req(1, F_H,    32'h3, 32'hFFFF, 32'h0, 1, 1, 0, 0, 0);
    do_req(0, 3'b011, 32'h4, 0, 32'h0, 1, 1, 0, 0, 0);
    do_req(1, F_BU,   32'h4, 32'hFF, 32'h0, 1, 1, 0, 0, 0);
    chk("err_store_mem1", mem[1], 32'h8081_7F02);
    do_req(0, F_HU, 32'h7E, 0, 32'h0000_DEAD, 0, 2, 1, 0, 0);
    do_req(0, F_B,  32'h7F, 0, 32'hFFFF_FFDE, 0, 2, 1, 0, 0);

    snap = mem[2];
    @(posedge clk); #1;
    wr_snap = tot_wr;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F_B; req_addr = 32'h9; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_memwrite", tot_wr - wr_snap, 32'h0);
    chk("rst_mid_mem2", mem[2], snap);

    do_req(0, F_W, 32'h7C, 0, 32'hDEAD_BEEF, 0, 2, 1, 0, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
